// File: rtl/isa_camac_io_decoder.sv
// ISA I/O-cycle front end for the SM2201 ISA-CAMAC board: window decode, back-end strobes, CHRDY wait states, IRQ routing.
// Optional wait-state timeout is compiled in with `define ISA_CHRDY_TIMEOUT_EN.
module isa_camac_io_decoder #(
    parameter logic [9:0] BASE_ADDR        = 10'h300,
    parameter int         NUM_CHANNELS     = 4,
    parameter int         REGS_PER_CHANNEL = 4,
    parameter int         MIN_WAIT         = 2,
    parameter int         TIMEOUT_CYCLES   = 64,
    parameter int         IRQ_LINES        = 8,
    localparam int        REG_SHIFT        = $clog2(REGS_PER_CHANNEL),
    localparam int        REG_BITS         = (REG_SHIFT < 1) ? 1 : REG_SHIFT
) (
    input  logic                    isa_clk,
    input  logic                    isa_reset,
    input  logic [9:0]              isa_addr,
    input  logic                    isa_ale,
    input  logic                    isa_aen,
    input  logic                    isa_ior,
    input  logic                    isa_iow,
    output logic                    isa_chrdy,
    output logic [IRQ_LINES-1:0]    isa_irq,
    output logic [NUM_CHANNELS-1:0] dev_sel,
    output logic [REG_BITS-1:0]     dev_reg,
    output logic                    dev_rd,
    output logic                    dev_wr,
    input  logic                    dev_ack,
    input  logic [NUM_CHANNELS-1:0] dev_irq,
    output logic                    timeout_err
);

    localparam int          WINDOW  = NUM_CHANNELS * REGS_PER_CHANNEL;
    localparam int          CNT_TOP = (MIN_WAIT > TIMEOUT_CYCLES) ? MIN_WAIT : TIMEOUT_CYCLES;
    localparam int          CW      = $clog2(CNT_TOP + 1);
    localparam logic [10:0] WIN_END = 11'(int'(BASE_ADDR) + WINDOW);
    localparam logic [CW-1:0] MIN_M1 = CW'(MIN_WAIT - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_HOLD
    } state_t;

    state_t                  state_q, state_d;
    logic [9:0]              addr_q, addr_d;
    logic [2:0]              ior_sync_q, ior_sync_d;
    logic [2:0]              iow_sync_q, iow_sync_d;
    logic                    rd_start_q, rd_start_d;
    logic                    wr_start_q, wr_start_d;
    logic                    chrdy_q, chrdy_d;
    logic [NUM_CHANNELS-1:0] dev_sel_q, dev_sel_d;
    logic [REG_BITS-1:0]     dev_reg_q, dev_reg_d;
    logic                    dev_rd_q, dev_rd_d;
    logic                    dev_wr_q, dev_wr_d;
    logic                    is_rd_q, is_rd_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic                    ack_seen_q, ack_seen_d;
    logic [IRQ_LINES-1:0]    irq_q, irq_d;
`ifdef ISA_CHRDY_TIMEOUT_EN
    localparam logic [CW-1:0] TO_M1 = CW'(TIMEOUT_CYCLES - 1);
    logic                    timeout_q, timeout_d;
`endif

    logic                    rd_edge, wr_edge, in_window, ack_now, strobe_released;
    logic [9:0]              addr_off;
    logic [9:0]              chan_idx;

    always_comb begin
        // NOTE: every variable assigned here gets a default first, so no path can infer a latch.
        addr_d     = isa_ale ? isa_addr : addr_q;
        ior_sync_d = {ior_sync_q[1:0], isa_ior};
        iow_sync_d = {iow_sync_q[1:0], isa_iow};
        rd_edge    = ior_sync_q[2] & ~ior_sync_q[1];
        wr_edge    = iow_sync_q[2] & ~iow_sync_q[1];
        // Simultaneous falling edges on both strobes never start a cycle.
        rd_start_d = rd_edge & ~wr_edge;
        wr_start_d = wr_edge & ~rd_edge;

        in_window  = ({1'b0, addr_q} >= {1'b0, BASE_ADDR}) && ({1'b0, addr_q} < WIN_END);
        addr_off   = addr_q - BASE_ADDR;
        chan_idx   = addr_off >> REG_SHIFT;
        ack_now    = dev_ack & ~(dev_rd_q | dev_wr_q);
        strobe_released = is_rd_q ? ior_sync_q[1] : iow_sync_q[1];

        state_d    = state_q;
        chrdy_d    = chrdy_q;
        dev_sel_d  = dev_sel_q;
        dev_reg_d  = dev_reg_q;
        dev_rd_d   = 1'b0;
        dev_wr_d   = 1'b0;
        is_rd_d    = is_rd_q;
        cnt_d      = cnt_q;
        ack_seen_d = ack_seen_q;
`ifdef ISA_CHRDY_TIMEOUT_EN
        timeout_d  = timeout_q;
`endif

        case (state_q)
            ST_IDLE: begin
                chrdy_d   = 1'b1;
                dev_sel_d = '0;
                if (!isa_aen && in_window &&
                    ((rd_start_q && iow_sync_q[1]) || (wr_start_q && ior_sync_q[1]))) begin
                    state_d    = ST_WAIT;
                    chrdy_d    = 1'b0;
                    dev_sel_d  = NUM_CHANNELS'(1) << chan_idx;
                    dev_reg_d  = addr_q[REG_BITS-1:0];
                    is_rd_d    = rd_start_q;
                    dev_rd_d   = rd_start_q;
                    dev_wr_d   = wr_start_q;
                    cnt_d      = '0;
                    ack_seen_d = 1'b0;
`ifdef ISA_CHRDY_TIMEOUT_EN
                    timeout_d  = 1'b0;
`endif
                end
            end
            ST_WAIT: begin
                if (cnt_q != '1) begin
                    cnt_d = cnt_q + 1'b1;
                end
                ack_seen_d = ack_seen_q | ack_now;
                if (strobe_released) begin
                    // Host abandoned the cycle before the back-end finished.
                    state_d   = ST_IDLE;
                    chrdy_d   = 1'b1;
                    dev_sel_d = '0;
                end else if ((ack_seen_q || ack_now) && (cnt_q >= MIN_M1)) begin
                    state_d = ST_HOLD;
                    chrdy_d = 1'b1;
                end
`ifdef ISA_CHRDY_TIMEOUT_EN
                else if (cnt_q >= TO_M1) begin
                    state_d   = ST_HOLD;
                    chrdy_d   = 1'b1;
                    timeout_d = 1'b1;
                end
`endif
            end
            ST_HOLD: begin
                chrdy_d = 1'b1;
                if (ior_sync_q[1] && iow_sync_q[1]) begin
                    state_d   = ST_IDLE;
                    dev_sel_d = '0;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                chrdy_d   = 1'b1;
                dev_sel_d = '0;
            end
        endcase

        irq_d = '0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            irq_d[i % IRQ_LINES] = irq_d[i % IRQ_LINES] | dev_irq[i];
        end
    end

    always_ff @(posedge isa_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (isa_reset) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            ior_sync_q <= '1;
            iow_sync_q <= '1;
            rd_start_q <= 1'b0;
            wr_start_q <= 1'b0;
            chrdy_q    <= 1'b1;
            dev_sel_q  <= '0;
            dev_reg_q  <= '0;
            dev_rd_q   <= 1'b0;
            dev_wr_q   <= 1'b0;
            is_rd_q    <= 1'b0;
            cnt_q      <= '0;
            ack_seen_q <= 1'b0;
            irq_q      <= '0;
`ifdef ISA_CHRDY_TIMEOUT_EN
            timeout_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            ior_sync_q <= ior_sync_d;
            iow_sync_q <= iow_sync_d;
            rd_start_q <= rd_start_d;
            wr_start_q <= wr_start_d;
            chrdy_q    <= chrdy_d;
            dev_sel_q  <= dev_sel_d;
            dev_reg_q  <= dev_reg_d;
            dev_rd_q   <= dev_rd_d;
            dev_wr_q   <= dev_wr_d;
            is_rd_q    <= is_rd_d;
            cnt_q      <= cnt_d;
            ack_seen_q <= ack_seen_d;
            irq_q      <= irq_d;
`ifdef ISA_CHRDY_TIMEOUT_EN
            timeout_q  <= timeout_d;
`endif
        end
    end

    assign isa_chrdy = chrdy_q;
    assign isa_irq   = irq_q;
    assign dev_sel   = dev_sel_q;
    assign dev_reg   = dev_reg_q;
    assign dev_rd    = dev_rd_q;
    assign dev_wr    = dev_wr_q;
`ifdef ISA_CHRDY_TIMEOUT_EN
    assign timeout_err = timeout_q;
`else
    assign timeout_err = 1'b0;
`endif

endmodule

// File: doc/isa_camac_io_decoder.md
# isa_camac_io_decoder

Parametrised ISA I/O-cycle front end for the SM2201 ISA–CAMAC interface board. It decodes a configurable I/O window into multiple channels, issues one-cycle read/write strobes to the back-end, and stretches the host cycle through `isa_chrdy` until the back-end acknowledges. It also routes per-channel interrupt requests onto ISA IRQ lines. It sits between the ISA edge connector and the CAMAC-side register logic.

## Interface

Parameters:
- `BASE_ADDR`, 10'h300: window base; must be aligned to the window size `NUM_CHANNELS*REGS_PER_CHANNEL`.
- `NUM_CHANNELS`, 4: number of decoded channels, 1..8.
- `REGS_PER_CHANNEL`, 4: registers per channel; power of two. `REG_BITS = clog2(REGS_PER_CHANNEL)`, minimum 1.
- `MIN_WAIT`, 2: minimum number of cycles `isa_chrdy` is held low per accepted cycle; must be ≥1.
- `TIMEOUT_CYCLES`, 64: wait-state limit, used only with the timeout macro.
- `IRQ_LINES`, 8: width of `isa_irq`.

Ports:
- `isa_clk`, in, 1: ISA bus clock; the only clock.
- `isa_reset`, in, 1: synchronous, active-high reset.
- `isa_addr`, in, 10: ISA I/O address SA[9:0].
- `isa_ale`, in, 1: address latch enable. The address is captured while it is high and held while it is low.
- `isa_aen`, in, 1: DMA address enable. When 1, the cycle is not for I/O and is ignored.
- `isa_ior`, in, 1: I/O read strobe, active-low.
- `isa_iow`, in, 1: I/O write strobe, active-low.
- `isa_chrdy`, out, 1: channel ready. 0 inserts wait states.
- `isa_irq`, out, `IRQ_LINES`: interrupt request lines, active-high.
- `dev_sel`, out, `NUM_CHANNELS`: one-hot channel select, held for the whole cycle.
- `dev_reg`, out, `REG_BITS`: register offset within the channel.
- `dev_rd`, out, 1: one-cycle read strobe.
- `dev_wr`, out, 1: one-cycle write strobe.
- `dev_ack`, in, 1: back-end done. It is a level or a pulse and is sampled from the cycle after `dev_rd`/`dev_wr`.
- `dev_irq`, in, `NUM_CHANNELS`: per-channel interrupt requests.
- `timeout_err`, out, 1: sticky timeout flag.

## Operation

Strobe synchronisation:
- `isa_ior` and `isa_iow` each pass through a 2-flop synchroniser plus a third flop used for edge detection.
- A cycle start is a synchronised falling edge on exactly one strobe.

State machine:
- **IDLE**
  - `isa_chrdy`=1 and `dev_sel`=0.
  - A cycle is accepted on a cycle start when all of the following hold: `isa_aen`=0; the other strobe is high; the latched address is in [`BASE_ADDR`, `BASE_ADDR`+window-1].
  - On acceptance:
    - channel = (addr-`BASE_ADDR`) / `REGS_PER_CHANNEL`; `dev_reg` = the low `REG_BITS` bits of the address.
    - Register the direction; pulse `dev_rd` or `dev_wr`.
    - Drive `isa_chrdy` to 0, clear `timeout_err`, clear the wait counter and the ack-seen flag, then go to WAIT.
  - Any other start (out of window, `isa_aen`=1, both strobes low) is ignored; `isa_chrdy` stays 1.
- **WAIT**
  - `isa_chrdy`=0. The counter increments each cycle, saturating.
  - `dev_ack`=1 sets the ack-seen flag.
  - Exit to HOLD on the first cycle where ack-seen (or `dev_ack` this cycle) is true and the counter ≥ `MIN_WAIT`-1.
  - If the synchronised strobe deasserts first (host abort), go to IDLE directly with no error.
- **HOLD**
  - `isa_chrdy`=1 and `dev_sel`/`dev_reg` are held.
  - When both synchronised strobes are high, go to IDLE and clear `dev_sel`.

Other rules:
- `dev_ack` outside WAIT is ignored.
- IRQ routing: `isa_irq[j]` is the registered OR of all `dev_irq[i]` with i mod `IRQ_LINES` == j.

## Timing

- Reset values:
  - `isa_chrdy`=1.
  - `dev_sel`, `dev_reg`, `dev_rd`, `dev_wr`, `isa_irq` and `timeout_err` all 0.
  - State IDLE; synchroniser flops preset to 1 (strobes inactive).
- Strobe latency: if a strobe is first sampled low at edge n, then `dev_rd`/`dev_wr` = 1 and `isa_chrdy` = 0 are seen after edge n+3. The strobe pulse lasts exactly 1 cycle.
- `isa_chrdy` low duration = max(`MIN_WAIT`, A+1) cycles, where A = number of cycles from the strobe pulse to the first `dev_ack`.
- IRQ latency is 1 cycle.
- Reset asserted in any state returns the block to IDLE at the next edge, with `isa_chrdy`=1 and `dev_sel`=0.

## Configuration

`ISA_CHRDY_TIMEOUT_EN` compiles in the wait-state timeout.

With the macro defined:
- If WAIT lasts `TIMEOUT_CYCLES` cycles without an ack, the block forces HOLD at the next edge, releasing `isa_chrdy`.
- `timeout_err` is set and stays set until the next accepted cycle or reset.

Without the macro:
- WAIT persists until ack or host abort.
- `timeout_err` is tied to 0.

## Test plan

All scenarios use the defaults: window 0x300–0x30F.
1. Read at 0x305, `dev_ack` 5 cycles after `dev_rd` → `dev_sel`=4'b0010, `dev_reg`=1, exactly one `dev_rd` pulse, `isa_chrdy` low 6 cycles, `dev_sel` cleared after `isa_ior` rises.
2. Write at 0x30F, `dev_ack` held at 1 → `dev_sel`=4'b1000, `dev_reg`=3, one `dev_wr` pulse, `isa_chrdy` low exactly 2 cycles.
3. Read at 0x310, then read at 0x304 with `isa_aen`=1, then both `isa_ior` and `isa_iow` low at 0x300 → no strobes, `isa_chrdy` stays 1 throughout.
4. Read at 0x300 with no ack → with the macro: `isa_chrdy` low 64 cycles then 1, `timeout_err`=1 until the next accepted cycle. Without the macro: `isa_chrdy` stays 0 until `isa_ior` rises, then 1 with `timeout_err`=0.
5. Assert `isa_reset` during WAIT → after the next edge `isa_chrdy`=1 and `dev_sel`=0; a following read at 0x308 is accepted normally.
6. `dev_irq`=4'b0100 → `isa_irq`=8'h04 one cycle later; `dev_irq`=0 → `isa_irq`=0 one cycle later.
